// File: rtl/rdwr_req_arb.sv
// Arbitrates read/write test-engine requests onto one AFU transmit port:
// round-robin grants, unsplit write packets, read line credit, almost-full stall.
module rdwr_req_arb #(
  parameter int ADDR_LMT    = 20,
  parameter int MAX_RD_PEND = 512
) (
  input  logic                Clk_400,
  input  logic                test_Resetb,
  input  logic                rw2ab_RdEn,
  input  logic [ADDR_LMT-1:0] rw2ab_RdAddr,
  input  logic [15:0]         rw2ab_RdTID,
  input  logic [1:0]          rw2ab_RdLen,
  input  logic                rw2ab_RdSop,
  input  logic                rw2ab_WrEn,
  input  logic [ADDR_LMT-1:0] rw2ab_WrAddr,
  input  logic [15:0]         rw2ab_WrTID,
  input  logic [511:0]        rw2ab_WrDin,
  input  logic [1:0]          rw2ab_WrLen,
  input  logic                rw2ab_WrSop,
  output logic                ab2rw_RdSent,
  output logic                ab2rw_WrSent,
  input  logic                ab2rw_RdRspValid,
  input  logic                tx_AlmFull,
  output logic                tx_Valid,
  output logic                tx_IsWr,
  output logic [ADDR_LMT-1:0] tx_Addr,
  output logic [15:0]         tx_TID,
  output logic [511:0]        tx_Data,
  output logic [1:0]          tx_Len,
  output logic                tx_Sop,
  output logic [9:0]          arb_RdPend,
  output logic [31:0]         arb_RdCnt,
  output logic [31:0]         arb_WrCnt,
  output logic                arb_Err
);

  // Handshake: RdEn/WrEn act as valid and stay up with a stable payload until the
  // matching RdSent/WrSent (ready) is seen in the same cycle; a beat transfers
  // exactly on a cycle where valid & sent are both 1.
  logic [1:0]  lockCnt;
  logic        lastWr;
  logic [9:0]  rdPend;
  logic        wrLock, rdOk, wrOk, grantRd, grantWr, rspUnderflow;
  logic [10:0] rdNeed, rdPendAdd, rdPendNext;

  assign wrLock  = (lockCnt != 2'd0);
  assign rdNeed  = {1'b0, rdPend} + {9'd0, rw2ab_RdLen} + 11'd1;
  assign rdOk    = rw2ab_RdEn & ~tx_AlmFull & ~wrLock & (rdNeed <= 11'(MAX_RD_PEND));
  assign wrOk    = rw2ab_WrEn & ~tx_AlmFull;
  // On a tie the type not granted last wins.
  assign grantWr = wrOk & (~rdOk | ~lastWr);
  assign grantRd = rdOk & (~wrOk | lastWr);

  assign ab2rw_RdSent = grantRd & test_Resetb;
  assign ab2rw_WrSent = grantWr & test_Resetb;
  assign arb_RdPend   = rdPend;

  always_comb begin
    rdPendAdd    = {1'b0, rdPend} + (grantRd ? ({9'd0, rw2ab_RdLen} + 11'd1) : 11'd0);
    rdPendNext   = rdPendAdd;
    rspUnderflow = 1'b0;
    if (ab2rw_RdRspValid) begin
      if (rdPendAdd == 11'd0) rspUnderflow = 1'b1;
      else                    rdPendNext   = rdPendAdd - 11'd1;
    end
  end

  always_ff @(posedge Clk_400 or negedge test_Resetb) begin
    if (!test_Resetb) begin
      lockCnt   <= 2'd0;
      lastWr    <= 1'b0;
      rdPend    <= 10'd0;
      arb_RdCnt <= 32'd0;
      arb_WrCnt <= 32'd0;
      arb_Err   <= 1'b0;
      tx_Valid  <= 1'b0;
      tx_IsWr   <= 1'b0;
      tx_Addr   <= '0;
      tx_TID    <= 16'd0;
      tx_Data   <= 512'd0;
      tx_Len    <= 2'd0;
      tx_Sop    <= 1'b0;
    end else begin
      rdPend <= rdPendNext[9:0];
      if (rspUnderflow) arb_Err <= 1'b1;
      tx_Valid <= grantWr | grantRd;
      if (grantWr) begin
        lastWr    <= 1'b1;
        arb_WrCnt <= arb_WrCnt + 32'd1;
        // Sop beat arms the lock with the beats still to come.
        if (rw2ab_WrSop) begin
          if (rw2ab_WrLen != 2'd0) lockCnt <= rw2ab_WrLen;
        end else if (lockCnt != 2'd0) begin
          lockCnt <= lockCnt - 2'd1;
        end
        tx_IsWr <= 1'b1;
        tx_Addr <= rw2ab_WrAddr;
        tx_TID  <= rw2ab_WrTID;
        tx_Data <= rw2ab_WrDin;
        tx_Len  <= rw2ab_WrLen;
        tx_Sop  <= rw2ab_WrSop;
      end else if (grantRd) begin
        lastWr    <= 1'b0;
        arb_RdCnt <= arb_RdCnt + 32'd1;
        tx_IsWr   <= 1'b0;
        tx_Addr   <= rw2ab_RdAddr;
        tx_TID    <= rw2ab_RdTID;
        tx_Len    <= rw2ab_RdLen;
        tx_Sop    <= rw2ab_RdSop;
      end
    end
  end

endmodule

// File: tb/tb_rdwr_req_arb.sv
// Bench for rdwr_req_arb: directed steps plus random traffic against a
// per-cycle reference model of the grant, credit, lock and output rules.
module tb_rdwr_req_arb;
  localparam int AW   = 20;
  localparam int MAXP = 7;

  logic          Clk_400 = 1'b0;
  logic          test_Resetb = 1'b1;
  logic          rw2ab_RdEn = 1'b0, rw2ab_RdSop = 1'b0, rw2ab_WrEn = 1'b0, rw2ab_WrSop = 1'b0;
  logic [AW-1:0] rw2ab_RdAddr = '0, rw2ab_WrAddr = '0;
  logic [15:0]   rw2ab_RdTID = '0, rw2ab_WrTID = '0;
  logic [1:0]    rw2ab_RdLen = '0, rw2ab_WrLen = '0;
  logic [511:0]  rw2ab_WrDin = '0;
  logic          ab2rw_RdRspValid = 1'b0, tx_AlmFull = 1'b0;
  logic          ab2rw_RdSent, ab2rw_WrSent, tx_Valid, tx_IsWr, tx_Sop, arb_Err;
  logic [AW-1:0] tx_Addr;
  logic [15:0]   tx_TID;
  logic [511:0]  tx_Data;
  logic [1:0]    tx_Len;
  logic [9:0]    arb_RdPend;
  logic [31:0]   arb_RdCnt, arb_WrCnt;

  rdwr_req_arb #(.ADDR_LMT(AW), .MAX_RD_PEND(MAXP)) dut (
    .Clk_400(Clk_400), .test_Resetb(test_Resetb),
    .rw2ab_RdEn(rw2ab_RdEn), .rw2ab_RdAddr(rw2ab_RdAddr), .rw2ab_RdTID(rw2ab_RdTID),
    .rw2ab_RdLen(rw2ab_RdLen), .rw2ab_RdSop(rw2ab_RdSop),
    .rw2ab_WrEn(rw2ab_WrEn), .rw2ab_WrAddr(rw2ab_WrAddr), .rw2ab_WrTID(rw2ab_WrTID),
    .rw2ab_WrDin(rw2ab_WrDin), .rw2ab_WrLen(rw2ab_WrLen), .rw2ab_WrSop(rw2ab_WrSop),
    .ab2rw_RdSent(ab2rw_RdSent), .ab2rw_WrSent(ab2rw_WrSent),
    .ab2rw_RdRspValid(ab2rw_RdRspValid), .tx_AlmFull(tx_AlmFull),
    .tx_Valid(tx_Valid), .tx_IsWr(tx_IsWr), .tx_Addr(tx_Addr), .tx_TID(tx_TID),
    .tx_Data(tx_Data), .tx_Len(tx_Len), .tx_Sop(tx_Sop),
    .arb_RdPend(arb_RdPend), .arb_RdCnt(arb_RdCnt), .arb_WrCnt(arb_WrCnt), .arb_Err(arb_Err)
  );

  // clock / reset
  always #5 Clk_400 = ~Clk_400;

  int total = 0;
  int bad = 0;

  // reference model state
  int            mPend, mLock;
  bit            mLastWr, mErr;
  logic [31:0]   mRdCnt, mWrCnt;
  logic          eValid, eIsWr, eSop;
  logic [AW-1:0] eAddr;
  logic [15:0]   eTID;
  logic [511:0]  eData;
  logic [1:0]    eLen;
  bit            gR, gW, obsRd, obsWr;

  // write packet source
  int pktLen, beatIdx;
  int fixLen = -1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_beat();
    rw2ab_WrSop  = (beatIdx == 0);
    rw2ab_WrLen  = 2'(pktLen - beatIdx);
    rw2ab_WrAddr = AW'($urandom);
    rw2ab_WrTID  = 16'($urandom);
    for (int k = 0; k < 16; k++) rw2ab_WrDin[k*32 +: 32] = $urandom;
  endtask

  task automatic new_pkt();
    pktLen  = (fixLen >= 0) ? fixLen : int'($urandom_range(0, 3));
    beatIdx = 0;
    load_beat();
  endtask

  task automatic model_reset();
    mPend = 0; mLock = 0; mLastWr = 0; mErr = 0; mRdCnt = '0; mWrCnt = '0;
    eValid = 0; eIsWr = 0; eSop = 0; eAddr = '0; eTID = '0; eData = '0; eLen = '0;
  endtask

  task automatic chk_regs(input string p);
    chk({p, "_tx_Valid"}, tx_Valid, eValid);
    chk({p, "_tx_IsWr"}, tx_IsWr, eIsWr);
    chk({p, "_tx_Addr"}, tx_Addr, eAddr);
    chk({p, "_tx_TID"}, tx_TID, eTID);
    chk({p, "_tx_Data"}, tx_Data, eData);
    chk({p, "_tx_Len"}, tx_Len, eLen);
    chk({p, "_tx_Sop"}, tx_Sop, eSop);
    chk({p, "_RdPend"}, arb_RdPend, 10'(mPend));
    chk({p, "_RdCnt"}, arb_RdCnt, mRdCnt);
    chk({p, "_WrCnt"}, arb_WrCnt, mWrCnt);
    chk({p, "_Err"}, arb_Err, mErr);
  endtask

  // driver: one clock cycle, entered and left at posedge+1
  task automatic cycle();
    bit canRd, canWr;
    rw2ab_RdAddr = AW'($urandom);
    rw2ab_RdTID  = 16'($urandom);
    rw2ab_RdSop  = 1'($urandom);
    #1;
    canRd = rw2ab_RdEn && !tx_AlmFull && (mLock == 0) && (mPend + int'(rw2ab_RdLen) + 1 <= MAXP);
    canWr = rw2ab_WrEn && !tx_AlmFull;
    if (canRd && canWr) begin gW = !mLastWr; gR = mLastWr; end
    else begin gW = canWr; gR = canRd; end
    obsRd = ab2rw_RdSent;
    obsWr = ab2rw_WrSent;
    chk("RdSent", obsRd, gR);
    chk("WrSent", obsWr, gW);
    @(posedge Clk_400);
    eValid = gR || gW;
    if (gW) begin
      mWrCnt++; mLastWr = 1;
      if (rw2ab_WrSop) mLock = rw2ab_WrLen; else if (mLock > 0) mLock--;
      eIsWr = 1; eAddr = rw2ab_WrAddr; eTID = rw2ab_WrTID; eData = rw2ab_WrDin;
      eLen = rw2ab_WrLen; eSop = rw2ab_WrSop;
    end else if (gR) begin
      mRdCnt++; mLastWr = 0; mPend += int'(rw2ab_RdLen) + 1;
      eIsWr = 0; eAddr = rw2ab_RdAddr; eTID = rw2ab_RdTID; eLen = rw2ab_RdLen; eSop = rw2ab_RdSop;
    end
    if (ab2rw_RdRspValid) begin
      if (mPend == 0) mErr = 1; else mPend--;
    end
    #1;
    chk_regs("cyc");
    if (gW) begin
      beatIdx++;
      if (beatIdx > pktLen) new_pkt(); else load_beat();
    end
  endtask

  // asynchronous reset dropped mid-cycle; outputs must clear with no clock edge
  task automatic do_reset();
    rw2ab_RdEn = 1; rw2ab_WrEn = 1; tx_AlmFull = 0;
    #2;
    test_Resetb = 0;
    #1;
    model_reset();
    chk_regs("rst");
    chk("rst_RdSent", ab2rw_RdSent, 1'b0);
    chk("rst_WrSent", ab2rw_WrSent, 1'b0);
    @(posedge Clk_400);
    #1;
    test_Resetb = 1;
    rw2ab_RdEn = 0; rw2ab_WrEn = 0; ab2rw_RdRspValid = 0; rw2ab_RdLen = 0;
  endtask

  initial begin
    bit expW[7], expR[7], alm[7];
    new_pkt();
    @(posedge Clk_400);
    #1;
    do_reset();

    // read-only stream up to the credit limit
    rw2ab_RdEn = 1; rw2ab_RdLen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("ro_grant", obsRd, (i < MAXP));
    end
    chk("ro_pend", arb_RdPend, 10'(MAXP));
    ab2rw_RdRspValid = 1;
    cycle();
    chk("ro_rsp_same", obsRd, 1'b0);
    ab2rw_RdRspValid = 0;
    cycle();
    chk("ro_rsp_next", obsRd, 1'b1);
    cycle();
    chk("ro_rsp_after", obsRd, 1'b0);

    // contention: alternate W,R,W,R from reset
    do_reset();
    fixLen = 0; new_pkt();
    rw2ab_RdEn = 1; rw2ab_WrEn = 1; rw2ab_RdLen = 0;
    for (int i = 0; i < 8; i++) begin
      ab2rw_RdRspValid = (mPend > 0);
      cycle();
      chk("cont_wr", obsWr, (i % 2 == 0));
      chk("cont_rd", obsRd, (i % 2 == 1));
      chk("cont_isWr", tx_IsWr, (i % 2 == 0));
    end
    ab2rw_RdRspValid = 0;

    // packet lock: four beats then the read
    do_reset();
    fixLen = 3; new_pkt();
    rw2ab_RdEn = 1; rw2ab_WrEn = 1; rw2ab_RdLen = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("lock_wr", obsWr, (i < 4));
      chk("lock_rd", obsRd, (i == 4));
      if (i < 4) chk("lock_sop", tx_Sop, (i == 0));
    end
    rw2ab_RdEn = 0; rw2ab_WrEn = 0;
    cycle();

    // same packet with almost-full during beat 2
    expW = '{1, 1, 0, 0, 1, 1, 0};
    expR = '{0, 0, 0, 0, 0, 0, 1};
    alm  = '{0, 0, 1, 1, 0, 0, 0};
    rw2ab_RdEn = 1; rw2ab_WrEn = 1;
    for (int i = 0; i < 7; i++) begin
      tx_AlmFull = alm[i];
      cycle();
      chk("stall_wr", obsWr, expW[i]);
      chk("stall_rd", obsRd, expR[i]);
    end
    tx_AlmFull = 0;

    // credit: grant and response together, then the exact limit
    do_reset();
    rw2ab_RdEn = 1; rw2ab_RdLen = 0;
    for (int i = 0; i < 5; i++) cycle();
    chk("cred_pend5", arb_RdPend, 10'd5);
    rw2ab_RdLen = 1; ab2rw_RdRspValid = 1;
    cycle();
    chk("cred_grant", obsRd, 1'b1);
    chk("cred_pend6", arb_RdPend, 10'd6);
    ab2rw_RdRspValid = 0;
    cycle();
    chk("cred_over", obsRd, 1'b0);
    rw2ab_RdLen = 0;
    cycle();
    chk("cred_fill", obsRd, 1'b1);
    chk("cred_pend7", arb_RdPend, 10'd7);

    // random traffic
    do_reset();
    fixLen = -1; new_pkt();
    for (int i = 0; i < 400; i++) begin
      rw2ab_RdEn = ($urandom_range(0, 2) != 0);
      rw2ab_RdLen = 2'($urandom_range(0, 3));
      rw2ab_WrEn = ($urandom_range(0, 3) != 0);
      tx_AlmFull = ($urandom_range(0, 7) == 0);
      ab2rw_RdRspValid = (mPend > 0) && ($urandom_range(0, 1) == 1);
      cycle();
    end
    tx_AlmFull = 0;

    // response underflow is sticky
    do_reset();
    ab2rw_RdRspValid = 1;
    cycle();
    chk("err_set", arb_Err, 1'b1);
    chk("err_pend", arb_RdPend, 10'd0);
    ab2rw_RdRspValid = 0;
    cycle();
    chk("err_sticky", arb_Err, 1'b1);

    // reset in the middle of a packet releases the lock
    do_reset();
    fixLen = 3; new_pkt();
    rw2ab_WrEn = 1; rw2ab_RdEn = 1;
    cycle();
    cycle();
    chk("mid_valid", tx_Valid, 1'b1);
    do_reset();
    rw2ab_RdEn = 1; rw2ab_RdLen = 0;
    cycle();
    chk("mid_unlock", obsRd, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
